instr_fetch: RTL and testbench

Instruction fetch stage of the MIPS datapath: holds the PC, requests 32-bit words from instruction memory over a req/ack handshake, and presents the fetched instruction and its opcode field to the control decoder. When the downstream stage accepts an instruction, it returns next-PC resolution for that instruction in the same cycle: sequential, branch, jump or jump-register. Fetch then computes the next address and issues the next request.

---
 rtl/mips_pkg.sv | 29 ++
 rtl/instr_fetch_if.sv | 46 ++++
 rtl/fetch_next_pc.sv | 33 +++
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: next-PC select encodings, fetch FSM states, constants.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds the FAULT state.
package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned BOFF_W  = 16;
  localparam int unsigned JIDX_W  = 26;
  localparam int unsigned NSEL_W  = 2;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [NSEL_W-1:0] {
    NPC_SEQ    = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_sel_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    ST_FAULT = 2'b10
`endif
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction memory handshake plus decode-side hand-off.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds fetch_fault.
interface instr_fetch_if;
  import mips_pkg::*;

  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_ack;
  logic [XLEN-1:0]   imem_rdata;
  logic [XLEN-1:0]   instr;
  logic [OPC_W-1:0]  opcode;
  logic [XLEN-1:0]   pc;
  logic [XLEN-1:0]   pc_plus4;
  logic              instr_valid;
  logic              instr_ready;
  logic [NSEL_W-1:0] nextpc_sel;
  logic              branch_taken;
  logic [BOFF_W-1:0] branch_offset;
  logic [JIDX_W-1:0] jump_index;
  logic [XLEN-1:0]   jr_target;
  logic [XLEN-1:0]   retired_count;
`ifdef FETCH_ALIGN_CHECK_EN
  logic              fetch_fault;
`endif

  // Fetch stage side
  modport master (
`ifdef FETCH_ALIGN_CHECK_EN
    output fetch_fault,
`endif
    output imem_req, imem_addr, instr, opcode, pc, pc_plus4, instr_valid, retired_count,
    input  imem_ack, imem_rdata, instr_ready, nextpc_sel, branch_taken,
           branch_offset, jump_index, jr_target
  );

  // Memory / downstream side
  modport slave (
`ifdef FETCH_ALIGN_CHECK_EN
    input  fetch_fault,
`endif
    input  imem_req, imem_addr, instr, opcode, pc, pc_plus4, instr_valid, retired_count,
    output imem_ack, imem_rdata, instr_ready, nextpc_sel, branch_taken,
           branch_offset, jump_index, jr_target
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Combinational next-PC resolution: sequential, branch, jump or jump-register.
module fetch_next_pc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0]   pc_i,
  input  logic [NSEL_W-1:0] sel_i,
  input  logic              branch_taken_i,
  input  logic [BOFF_W-1:0] branch_offset_i,
  input  logic [JIDX_W-1:0] jump_index_i,
  input  logic [XLEN-1:0]   jr_target_i,
  output logic [XLEN-1:0]   pc_plus4_o,
  output logic [XLEN-1:0]   next_pc_o
);

  logic [XLEN-1:0] br_disp_c;

  assign pc_plus4_o = pc_i + 32'd4;
  // Word offset sign-extended and scaled to bytes
  assign br_disp_c  = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};

  // Select target; all additions wrap modulo 2^32
  always_comb begin
    next_pc_o = pc_plus4_o;
    case (npc_sel_e'(sel_i))
      NPC_SEQ:    next_pc_o = pc_plus4_o;
      NPC_BRANCH: next_pc_o = branch_taken_i ? (pc_plus4_o + br_disp_c) : pc_plus4_o;
      NPC_JUMP:   next_pc_o = {pc_plus4_o[31:28], jump_index_i, 2'b00};
      NPC_JR:     next_pc_o = jr_target_i;
      default:    next_pc_o = pc_plus4_o;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// MIPS instruction fetch stage: PC, imem req/ack handshake, hand-off to decode.
// Optional feature macro: FETCH_ALIGN_CHECK_EN traps misaligned next-PC into FAULT.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic [XLEN-1:0] pc_plus4_c, npc_raw_c, npc_c;
  logic            fetch_ack_c, accept_c;
`ifdef FETCH_ALIGN_CHECK_EN
  logic            misalign_c;
`endif

  fetch_next_pc u_next_pc (
    .pc_i            (pc_q),
    .sel_i           (bus.nextpc_sel),
    .branch_taken_i  (bus.branch_taken),
    .branch_offset_i (bus.branch_offset),
    .jump_index_i    (bus.jump_index),
    .jr_target_i     (bus.jr_target),
    .pc_plus4_o      (pc_plus4_c),
    .next_pc_o       (npc_raw_c)
  );

`ifdef FETCH_ALIGN_CHECK_EN
  assign npc_c      = npc_raw_c;
  assign misalign_c = |npc_raw_c[1:0];
`else
  // Without the trap, targets are silently word-aligned
  assign npc_c      = npc_raw_c & ~32'h0000_0003;
`endif

  assign fetch_ack_c = (state_q == ST_FETCH) && bus.imem_ack;
  assign accept_c    = (state_q == ST_HOLD) && bus.instr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (bus.imem_ack) state_d = ST_HOLD;
      ST_HOLD: begin
        if (bus.instr_ready) begin
`ifdef FETCH_ALIGN_CHECK_EN
          state_d = misalign_c ? ST_FAULT : ST_FETCH;
`else
          state_d = ST_FETCH;
`endif
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      ST_FAULT: state_d = ST_FAULT;
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  // Datapath registers: pc, captured instruction, retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= INSTR_NOP;
      retired_q <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  // Datapath next values; a trapped target leaves pc at the faulting instruction
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    if (fetch_ack_c) instr_d = bus.imem_rdata;
    if (accept_c) begin
      retired_d = retired_q + 32'd1;
`ifdef FETCH_ALIGN_CHECK_EN
      if (!misalign_c) pc_d = npc_c;
`else
      pc_d = npc_c;
`endif
    end
  end

  // State-decoded outputs; request and valid are forced low while in reset
  always_comb begin
    bus.imem_req    = 1'b0;
    bus.instr_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    bus.fetch_fault = 1'b0;
`endif
    if (!rst) begin
      case (state_q)
        ST_FETCH: bus.imem_req    = 1'b1;
        ST_HOLD:  bus.instr_valid = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        ST_FAULT: bus.fetch_fault = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign bus.imem_addr     = pc_q;
  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4_c;
  assign bus.instr         = instr_q;
  assign bus.opcode        = instr_q[31:26];
  assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory/downstream model, expected fetch addresses
// and instructions queued on stimulus, compared when the DUT presents them.
// Optional feature macro: FETCH_ALIGN_CHECK_EN selects the misaligned-target expectations.
module tb_instr_fetch;
  import mips_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } fe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] exp_retired = '0;
  logic [31:0] exp_addr_q[$];
  fe_t         exp_fe_q[$];

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [1:0] sel,
                                           input logic taken, input logic [15:0] off,
                                           input logic [25:0] idx, input logic [31:0] jr);
    logic [31:0] p4, r;
    logic signed [31:0] soff;
    p4   = pc + 32'd4;
    soff = 32'($signed(off));
    case (sel)
      2'b01:   r = taken ? p4 + 32'(soff * 4) : p4;
      2'b10:   r = {p4[31:28], idx, 2'b00};
      2'b11:   r = jr;
      default: r = p4;
    endcase
`ifndef FETCH_ALIGN_CHECK_EN
    r[1:0] = 2'b00;
`endif
    return r;
  endfunction

  task automatic reset_dut();
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.instr_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_req", 32'(bus.imem_req), 32'd0);
      check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
      check_eq("rst_retired", bus.retired_count, 32'd0);
      check_eq("rst_pc", bus.pc, RST_PC);
      check_eq("rst_instr", bus.instr, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
      check_eq("rst_fault", 32'(bus.fetch_fault), 32'd0);
`endif
    end
    rst = 1'b0;
    #1;
    check_eq("post_rst_req", 32'(bus.imem_req), 32'd1);
    exp_addr_q.delete();
    exp_fe_q.delete();
    exp_addr_q.push_back(RST_PC);
    exp_retired = '0;
  endtask

  // Memory side: wait for request, optionally stall the ack, then return rdata
  task automatic fetch_one(input logic [31:0] rdata, input int ack_delay);
    logic [31:0] ea;
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.imem_req) begin
      check_eq("req_timeout", 32'(bus.imem_req), 32'd1);
      return;
    end
    ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hDEAD_BEEF;
    check_eq("imem_addr", bus.imem_addr, ea);
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk);
      check_eq("req_stall", 32'(bus.imem_req), 32'd1);
      check_eq("addr_stall", bus.imem_addr, ea);
    end
    exp_fe_q.push_back('{pc: ea, instr: rdata});
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hBAD0_BAD0;
  endtask

  // Downstream side: check presented instruction, optionally stall, then accept
  task automatic accept_one(input int ready_delay, input logic [1:0] sel, input logic taken,
                            input logic [15:0] off, input logic [25:0] idx,
                            input logic [31:0] jr);
    fe_t e;
    logic [31:0] npc;
    int n = 0;
    while (!bus.instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_valid) begin
      check_eq("valid_timeout", 32'(bus.instr_valid), 32'd1);
      return;
    end
    e = (exp_fe_q.size() > 0) ? exp_fe_q.pop_front() : '{pc: 32'hDEAD_BEEF, instr: 32'hDEAD_BEEF};
    check_eq("instr", bus.instr, e.instr);
    check_eq("opcode", 32'(bus.opcode), 32'(e.instr[31:26]));
    check_eq("pc", bus.pc, e.pc);
    check_eq("pc_plus4", bus.pc_plus4, e.pc + 32'd4);
    check_eq("hold_req", 32'(bus.imem_req), 32'd0);
    for (int i = 0; i < ready_delay; i++) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check_eq("stall_instr", bus.instr, e.instr);
      check_eq("stall_pc", bus.pc, e.pc);
      check_eq("stall_valid", 32'(bus.instr_valid), 32'd1);
      check_eq("stall_retired", bus.retired_count, exp_retired);
    end
    bus.imem_ack      = 1'b0;
    bus.instr_ready   = 1'b1;
    bus.nextpc_sel    = sel;
    bus.branch_taken  = taken;
    bus.branch_offset = off;
    bus.jump_index    = idx;
    bus.jr_target     = jr;
    npc = model_npc(e.pc, sel, taken, off, idx, jr);
    @(negedge clk);
    bus.instr_ready = 1'b0;
    exp_retired++;
    check_eq("retired", bus.retired_count, exp_retired);
    check_eq("valid_drop", 32'(bus.instr_valid), 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
    if (npc[1:0] != 2'b00) begin
      check_eq("fault", 32'(bus.fetch_fault), 32'd1);
      check_eq("fault_req", 32'(bus.imem_req), 32'd0);
      check_eq("fault_pc", bus.pc, e.pc);
    end else begin
      check_eq("no_fault", 32'(bus.fetch_fault), 32'd0);
      exp_addr_q.push_back(npc);
    end
`else
    exp_addr_q.push_back(npc);
`endif
  endtask

  initial begin
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    bus.instr_ready   = 1'b0;
    bus.nextpc_sel    = 2'b00;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = '0;
    bus.jump_index    = '0;
    bus.jr_target     = '0;

    reset_dut();

    // Zero-wait sequential fetch
    fetch_one(32'h2008_0005, 0);
    accept_one(0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    // Walk to 0x00400010
    for (int i = 0; i < 3; i++) begin
      fetch_one($urandom, 0);
      accept_one(0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    end
    // Branch -1 taken back to itself, then not taken
    fetch_one($urandom, 0);
    accept_one(0, 2'b01, 1'b1, 16'hFFFF, 26'h0, 32'h0);
    fetch_one($urandom, 0);
    accept_one(0, 2'b01, 1'b0, 16'hFFFF, 26'h0, 32'h0);
    // Walk to 0x00400020, then jump to 0x0040000C
    for (int i = 0; i < 3; i++) begin
      fetch_one($urandom, 1);
      accept_one(1, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    end
    fetch_one(32'h0810_0003, 0);
    accept_one(0, 2'b10, 1'b0, 16'h0, 26'h010_0003, 32'h0);
    // Downstream stall with stray acks, then jr
    fetch_one($urandom, 0);
    accept_one(3, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0040_0100);
    // Memory stall, then jr to a misaligned target
    fetch_one($urandom, 4);
    accept_one(0, 2'b11, 1'b0, 16'h0, 26'h0, 32'h0040_0102);
`ifdef FETCH_ALIGN_CHECK_EN
    repeat (3) begin
      @(negedge clk);
      check_eq("fault_hold", 32'(bus.fetch_fault), 32'd1);
      check_eq("fault_hold_req", 32'(bus.imem_req), 32'd0);
      check_eq("fault_hold_valid", 32'(bus.instr_valid), 32'd0);
    end
`else
    fetch_one($urandom, 0);
`endif
    // Mid-operation reset, then resume from reset PC
    reset_dut();
    fetch_one(32'h8C08_0000, 2);
    accept_one(0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    fetch_one($urandom, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
